// File: rtl/zeroheti_obi_apb_bridge.sv
// OBI-to-APB4 bridge with a single outstanding transaction: accept, SETUP, ACCESS, one-cycle response.
// Optional ACCESS-phase timeout is enabled by defining ZEROHETI_APB_TIMEOUT_EN.
module zeroheti_obi_apb_bridge #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                obi_req_i,
  output logic                obi_gnt_o,
  input  logic [ADDR_W-1:0]   obi_addr_i,
  input  logic                obi_we_i,
  input  logic [DATA_W/8-1:0] obi_be_i,
  input  logic [DATA_W-1:0]   obi_wdata_i,
  output logic                obi_rvalid_o,
  output logic [DATA_W-1:0]   obi_rdata_o,
  output logic                obi_err_o,
  output logic [ADDR_W-1:0]   paddr_o,
  output logic                psel_o,
  output logic                penable_o,
  output logic                pwrite_o,
  output logic [DATA_W-1:0]   pwdata_o,
  output logic [DATA_W/8-1:0] pstrb_o,
  output logic [2:0]          pprot_o,
  input  logic [DATA_W-1:0]   prdata_i,
  input  logic                pready_i,
  input  logic                pslverr_i
);

  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-3:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [STRB_W-1:0]   strb_q, strb_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                rvalid_q, rvalid_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                timeout_c;
  logic [1:0]          unused_addr;

  // Word-aligned APB address: the byte offset is carried by the strobes.
  assign unused_addr = obi_addr_i[1:0];

  assign obi_gnt_o    = obi_req_i && (state_q == IDLE);
  assign obi_rvalid_o = rvalid_q;
  assign obi_rdata_o  = rdata_q;
  assign obi_err_o    = err_q;
  assign paddr_o      = {addr_q, 2'b00};
  assign psel_o       = psel_q;
  assign penable_o    = penable_q;
  assign pwrite_o     = we_q;
  assign pwdata_o     = wdata_q;
  assign pstrb_o      = strb_q;
  assign pprot_o      = 3'b000;

`ifdef ZEROHETI_APB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Wait-state counter: abort once TIMEOUT_CYCLES waits elapsed and pready is still low.
  assign timeout_c = (32'(cnt_q) == TIMEOUT_CYCLES);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == SETUP) begin
      cnt_d = '0;
    end else if ((state_q == ACCESS) && !pready_i && !timeout_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  logic [31:0] unused_timeout;

  assign timeout_c      = 1'b0;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    strb_d    = strb_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (obi_req_i) begin
          addr_d  = obi_addr_i[ADDR_W-1:2];
          we_d    = obi_we_i;
          strb_d  = obi_we_i ? obi_be_i : '0;
          wdata_d = obi_wdata_i;
          state_d = SETUP;
        end
      end
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        if (pready_i) begin
          rdata_d = (we_q || pslverr_i) ? '0 : prdata_i;
          err_d   = pslverr_i;
          state_d = RESP;
        end else if (timeout_c) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    psel_d    = (state_d == SETUP) || (state_d == ACCESS);
    penable_d = (state_d == ACCESS);
    rvalid_d  = (state_d == RESP);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      strb_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      rvalid_q  <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      strb_q    <= strb_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      rvalid_q  <= rvalid_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
    end
  end

endmodule

// File: tb/tb_zeroheti_obi_apb_bridge.sv
// Bench for zeroheti_obi_apb_bridge: a transaction-level timeline model fills per-cycle expectations,
// a negedge compare process checks every cycle. Honours ZEROHETI_APB_TIMEOUT_EN (timeout of 4 waits).
module tb_zeroheti_obi_apb_bridge;

  localparam int NCYC = 8192;
  localparam int TO   = 4;
`ifdef ZEROHETI_APB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        obi_req_i, obi_gnt_o, obi_we_i, obi_rvalid_o, obi_err_o;
  logic [31:0] obi_addr_i, obi_wdata_i, obi_rdata_o;
  logic [3:0]  obi_be_i, pstrb_o;
  logic [31:0] paddr_o, pwdata_o, prdata_i;
  logic        psel_o, penable_o, pwrite_o, pready_i, pslverr_i;
  logic [2:0]  pprot_o;

  zeroheti_obi_apb_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .obi_req_i(obi_req_i), .obi_gnt_o(obi_gnt_o), .obi_addr_i(obi_addr_i), .obi_we_i(obi_we_i),
    .obi_be_i(obi_be_i), .obi_wdata_i(obi_wdata_i), .obi_rvalid_o(obi_rvalid_o),
    .obi_rdata_o(obi_rdata_o), .obi_err_o(obi_err_o),
    .paddr_o(paddr_o), .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .pwdata_o(pwdata_o), .pstrb_o(pstrb_o), .pprot_o(pprot_o),
    .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        gnt, psel, pen, rv, pwrite, err;
    logic [31:0] paddr, pwdata, rdata;
    logic [3:0]  pstrb;
  } exp_t;

  exp_t exp_mem [NCYC];
  int   cyc = 0;
  int   n_pass = 0, n_total = 0;
  bit   chk_en = 1'b0;
  int   t_start, last_gnt = -1, prev_gnt = -1, last_rv = -1, setup_cyc = -1, rv_cnt = 0, viol = 0;
  logic [31:0] last_rdata, setup_paddr;
  logic [3:0]  setup_pstrb;
  logic        last_err;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    else n_pass++;
  endtask

  // Per-cycle compare against the model timeline, plus observation capture for literal checks.
  always @(negedge clk_i) begin
    if (chk_en && cyc < NCYC) begin
      exp_t e;
      e = exp_mem[cyc];
      chk("gnt", 32'(obi_gnt_o), 32'(e.gnt));
      chk("psel", 32'(psel_o), 32'(e.psel));
      chk("penable", 32'(penable_o), 32'(e.pen));
      chk("rvalid", 32'(obi_rvalid_o), 32'(e.rv));
      chk("pprot", 32'(pprot_o), 32'd0);
      if (e.psel) begin
        chk("paddr", paddr_o, e.paddr);
        chk("pwrite", 32'(pwrite_o), 32'(e.pwrite));
        chk("pstrb", 32'(pstrb_o), 32'(e.pstrb));
        if (e.pwrite) chk("pwdata", pwdata_o, e.pwdata);
      end
      if (e.rv) begin
        chk("rdata", obi_rdata_o, e.rdata);
        chk("err", 32'(obi_err_o), 32'(e.err));
      end
    end
    if (chk_en) begin
      if (obi_gnt_o) begin prev_gnt = last_gnt; last_gnt = cyc; end
      if (psel_o && !penable_o) begin setup_cyc = cyc; setup_paddr = paddr_o; setup_pstrb = pstrb_o; end
      if (obi_rvalid_o) begin last_rv = cyc; last_rdata = obi_rdata_o; last_err = obi_err_o; rv_cnt++; end
      if (obi_gnt_o && obi_rvalid_o) viol++;
    end
  end

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic junk_obi();
    obi_addr_i = $urandom; obi_we_i = 1'($urandom); obi_be_i = 4'($urandom); obi_wdata_i = $urandom;
  endtask

  task automatic junk_apb();
    pready_i = 1'($urandom); prdata_i = $urandom; pslverr_i = 1'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      obi_req_i = 1'b0; junk_obi(); junk_apb(); next_cycle();
    end
  endtask

  // One OBI transaction; APB completes after `waits` wait states (or times out in the model).
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata, input logic [31:0] rd, input int waits,
                         input logic slverr, input logic hold);
    int t0, acc_n, idx;
    bit abort;
    t0 = cyc; t_start = t0;
    abort = TO_EN && (waits > TO);
    acc_n = abort ? TO + 1 : waits + 1;
    if (t0 < NCYC) exp_mem[t0].gnt = 1'b1;
    for (int i = 0; i <= acc_n; i++) begin
      idx = t0 + 1 + i;
      if (idx < NCYC) begin
        exp_mem[idx].psel = 1'b1; exp_mem[idx].pen = (i > 0);
        exp_mem[idx].paddr = {addr[31:2], 2'b00}; exp_mem[idx].pwrite = we;
        exp_mem[idx].pwdata = wdata; exp_mem[idx].pstrb = we ? be : 4'h0;
      end
    end
    idx = t0 + 2 + acc_n;
    if (idx < NCYC) begin
      exp_mem[idx].rv = 1'b1; exp_mem[idx].err = abort | slverr;
      exp_mem[idx].rdata = (abort || we || slverr) ? 32'h0 : rd;
    end
    obi_req_i = 1'b1; obi_addr_i = addr; obi_we_i = we; obi_be_i = be; obi_wdata_i = wdata;
    junk_apb();
    next_cycle();
    obi_req_i = hold; junk_obi(); junk_apb();
    for (int i = 0; i < acc_n; i++) begin
      next_cycle();
      if (!abort && i == waits) begin pready_i = 1'b1; prdata_i = rd; pslverr_i = slverr; end
      else begin pready_i = 1'b0; prdata_i = $urandom; pslverr_i = 1'($urandom); end
      junk_obi();
    end
    next_cycle();
    junk_apb(); junk_obi();
    next_cycle();
    obi_req_i = hold; junk_apb();
  endtask

  // Read with several wait states, reset pulsed during the 2nd wait cycle.
  task automatic reset_mid();
    int t0;
    t0 = cyc;
    exp_mem[t0].gnt = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      exp_mem[t0+i].psel = 1'b1; exp_mem[t0+i].pen = (i > 1);
      exp_mem[t0+i].paddr = 32'h300; exp_mem[t0+i].pwrite = 1'b0; exp_mem[t0+i].pstrb = 4'h0;
    end
    obi_req_i = 1'b1; obi_addr_i = 32'h300; obi_we_i = 1'b0; obi_be_i = 4'hF; obi_wdata_i = 32'h0;
    next_cycle(); obi_req_i = 1'b0; pready_i = 1'b0;
    next_cycle(); pready_i = 1'b0;
    next_cycle(); pready_i = 1'b0; rst_i = 1'b1;
    next_cycle(); rst_i = 1'b0;
  endtask

  initial begin
    int rv0;
    #1000000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int rv0;
    for (int i = 0; i < NCYC; i++) exp_mem[i] = '0;
    rst_i = 1'b1; obi_req_i = 1'b0; junk_obi(); pready_i = 1'b0; prdata_i = '0; pslverr_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_gnt", 32'(obi_gnt_o), 32'd0);
    chk("rst_rvalid", 32'(obi_rvalid_o), 32'd0);
    chk("rst_psel_pen", 32'({psel_o, penable_o}), 32'd0);
    chk("rst_paddr", paddr_o, 32'd0);
    chk("rst_pwrite_strb", 32'({pwrite_o, pstrb_o}), 32'd0);
    chk("rst_rdata", obi_rdata_o, 32'd0);
    chk("rst_err", 32'(obi_err_o), 32'd0);
    @(posedge clk_i); #1;
    chk_en = 1'b1;

    // Zero-wait write.
    run_txn(1'b1, 32'h0000_0104, 4'hF, 32'hDEAD_BEEF, 32'h5555_AAAA, 0, 1'b0, 1'b0);
    chk("wr_gnt_cyc", 32'(last_gnt - t_start), 32'd0);
    chk("wr_setup_cyc", 32'(setup_cyc - t_start), 32'd1);
    chk("wr_setup_paddr", setup_paddr, 32'h104);
    chk("wr_setup_pstrb", 32'(setup_pstrb), 32'hF);
    chk("wr_rv_lat", 32'(last_rv - t_start), 32'd3);
    chk("wr_rdata", last_rdata, 32'd0);
    chk("wr_err", 32'(last_err), 32'd0);
    idle(2);

    // Read with five wait states (aborted after four when the timeout is built in).
    run_txn(1'b0, 32'h0000_0200, 4'hF, 32'h0, 32'h1234_5678, 5, 1'b0, 1'b0);
    chk("rd5_lat", 32'(last_rv - t_start), TO_EN ? 32'd7 : 32'd8);
    chk("rd5_rdata", last_rdata, TO_EN ? 32'h0 : 32'h1234_5678);
    chk("rd5_pstrb", 32'(setup_pstrb), 32'h0);
    idle(1);

    // Read error: data forced to zero.
    run_txn(1'b0, 32'h0000_0208, 4'hF, 32'h0, 32'hFFFF_FFFF, 1, 1'b1, 1'b0);
    chk("rderr_err", 32'(last_err), 32'd1);
    chk("rderr_rdata", last_rdata, 32'd0);

    // Request held across two back-to-back transfers.
    run_txn(1'b1, 32'h0000_0010, 4'h3, 32'hA5A5_0001, 32'h0, 0, 1'b0, 1'b1);
    run_txn(1'b0, 32'h0000_0017, 4'h1, 32'h0, 32'h0BAD_F00D, 0, 1'b0, 1'b0);
    chk("b2b_gnt_gap", 32'(last_gnt - prev_gnt), 32'd4);
    chk("b2b_setup_paddr", setup_paddr, 32'h14);
    idle(1);

    // Reset during ACCESS: transfer dropped, grant available right after.
    rv0 = rv_cnt;
    reset_mid();
    run_txn(1'b0, 32'h0000_0020, 4'hF, 32'h0, 32'h0000_0042, 0, 1'b0, 1'b0);
    chk("rst_mid_gnt", 32'(last_gnt - t_start), 32'd0);
    chk("rst_mid_rv_cnt", 32'(rv_cnt - rv0), 32'd1);
    chk("rst_mid_rdata", last_rdata, 32'h42);

    // Stuck peripheral: 1000 wait states.
    rv0 = rv_cnt;
    run_txn(1'b0, 32'h0000_0400, 4'hF, 32'h0, 32'h7777_7777, 1000, 1'b0, 1'b0);
    chk("stuck_lat", 32'(last_rv - t_start), TO_EN ? 32'd7 : 32'd1003);
    chk("stuck_rv_cnt", 32'(rv_cnt - rv0), 32'd1);
    chk("stuck_err", 32'(last_err), TO_EN ? 32'd1 : 32'd0);
    idle(1);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      logic hold;
      hold = ($urandom_range(0, 2) == 0);
      run_txn(1'($urandom), $urandom, 4'($urandom), $urandom, $urandom, $urandom_range(0, 6),
              ($urandom_range(0, 3) == 0), hold);
      if (!hold) idle($urandom_range(0, 2));
    end
    idle(3);
    chk("gnt_during_rvalid", 32'(viol), 32'd0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
